// File: rtl/systolic_feeder.sv
// Frame-buffering feeder for the systolic array: collects feature column vectors,
// then replays them with a one-cycle-per-row diagonal skew and signals frame completion.

module systolic_feeder_lane #(
    parameter int width  = 8,
    parameter int stages = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en_in,
    input  logic [width-1:0] data_in,
    output logic             en_out,
    output logic [width-1:0] data_out
);
    // stages+1 registers; data is zeroed on entry so disabled slots never carry stale values
    logic [stages:0]  vld_pipe;
    logic [width-1:0] data_pipe [stages:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_pipe <= '0;
            for (int i = 0; i <= stages; i++) data_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= en_in;
            data_pipe[0] <= en_in ? data_in : '0;
            for (int i = 1; i <= stages; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign en_out   = vld_pipe[stages];
    assign data_out = data_pipe[stages];
endmodule

module systolic_feeder #(
    parameter int width = 8,
    parameter int row   = 4,
    parameter int depth = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic                     vec_last,
    input  logic [width-1:0]         vec_data    [row-1:0],
    output logic [width-1:0]         feature_out [row-1:0],
    output logic                     in_en       [row-1:0],
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(depth):0]   frame_len
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(row) + 1;

    typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;

    state_t                     state;
    logic [CW-1:0]              count;
    logic [AW-1:0]              rd_ptr;
    logic [FW-1:0]              fl_cnt;
    logic [row-1:0][width-1:0]  mem [depth];
    logic                       accept;
    logic                       last_beat;
    logic                       drain_en;

    // vec_ready is only high in FILL, where count < depth always holds
    assign accept    = vec_valid && vec_ready;
    assign last_beat = vec_last || (count == CW'(depth - 1));
    assign drain_en  = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < row; r++) mem[count[AW-1:0]][r] <= vec_data[r];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= FILL;
            count      <= '0;
            rd_ptr     <= '0;
            fl_cnt     <= '0;
            vec_ready  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (count == '0) frame_len <= '0;
                        if (last_beat) begin
                            frame_len <= count + CW'(1);
                            state     <= DRAIN;
                            rd_ptr    <= '0;
                            vec_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if ({1'b0, rd_ptr} + CW'(1) == frame_len) begin
                        state  <= FLUSH;
                        fl_cnt <= '0;
                    end
                end
                FLUSH: begin
                    fl_cnt <= fl_cnt + FW'(1);
                    if (fl_cnt == FW'(row - 1)) begin
                        state      <= FILL;
                        count      <= '0;
                        vec_ready  <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // row g sits g cycles behind row 0
    for (genvar g = 0; g < row; g++) begin : g_lane
        systolic_feeder_lane #(
            .width  (width),
            .stages (g)
        ) u_lane (
            .clk      (clk),
            .nrst     (nrst),
            .en_in    (drain_en),
            .data_in  (mem[rd_ptr][g]),
            .en_out   (in_en[g]),
            .data_out (feature_out[g])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: frame-level reference model checked every cycle,
// a table of frame shapes with hand-computed results, and corner-case sequences.

module tb_systolic_feeder;
    localparam int W     = 8;
    localparam int ROW   = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           nrst;
    logic           vec_valid;
    logic           vec_ready;
    logic           vec_last;
    logic [W-1:0]   vec_data    [ROW-1:0];
    logic [W-1:0]   feature_out [ROW-1:0];
    logic           in_en       [ROW-1:0];
    logic           busy;
    logic           frame_done;
    logic [4:0]     frame_len;

    systolic_feeder #(.width(W), .row(ROW), .depth(DEPTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .vec_last    (vec_last),
        .vec_data    (vec_data),
        .feature_out (feature_out),
        .in_en       (in_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_len   (frame_len)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int n; int base; } frame_t;
    typedef struct {
        int nvec; bit mark_last; bit gaps; bit const7;
        int exp_len; int exp_done; int exp_busy; int exp_sum;
    } vec_t;

    int       cyc, checks, errors;
    frame_t   frames[$];
    logic [W-1:0] acc_vec [0:4095][ROW];
    int       acc_n, cur_n, cur_base, exp_len, acc_cyc;
    bit       acc_flag;
    bit       exp_ready, exp_busy, exp_done;
    logic [ROW-1:0] exp_en;
    logic [W-1:0]   exp_feat [ROW];
    int       st_busy, st_en, st_sum, st_len, obs_done_cyc, obs_busy_rise;
    bit       done_seen, prev_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        frames.delete();
        cur_n    = 0;
        cur_base = acc_n;
        exp_len  = 0;
    endtask

    // Expected outputs at cycle c, derived from each frame's drain start t and length n
    task automatic model_expect(input int c);
        while (frames.size() > 0 && c > frames[0].t + frames[0].n + ROW) void'(frames.pop_front());
        exp_busy = 0; exp_done = 0; exp_en = '0;
        for (int r = 0; r < ROW; r++) exp_feat[r] = '0;
        foreach (frames[k]) begin
            if (c >= frames[k].t && c <= frames[k].t + frames[k].n + ROW - 1) exp_busy = 1;
            if (c == frames[k].t + frames[k].n + ROW) exp_done = 1;
            for (int r = 0; r < ROW; r++) begin
                int idx;
                idx = c - frames[k].t - 1 - r;
                if (idx >= 0 && idx < frames[k].n) begin
                    exp_en[r]   = 1'b1;
                    exp_feat[r] = acc_vec[frames[k].base + idx][r];
                end
            end
        end
        exp_ready = !exp_busy;
    endtask

    task automatic model_accept();
        if (cur_n == 0) exp_len = 0;
        for (int r = 0; r < ROW; r++) acc_vec[acc_n][r] = vec_data[r];
        acc_n++; cur_n++;
        acc_flag = 1;
        acc_cyc  = cyc;
        if (vec_last || cur_n == DEPTH) begin
            frames.push_back('{t: cyc + 1, n: cur_n, base: cur_base});
            exp_len  = cur_n;
            cur_base = acc_n;
            cur_n    = 0;
        end
    endtask

    task automatic step();
        logic [ROW-1:0] en_v;
        @(negedge clk);
        if (!nrst) model_reset();
        model_expect(cyc);
        for (int r = 0; r < ROW; r++) en_v[r] = in_en[r];
        check("vec_ready", 32'(vec_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(exp_busy));
        check("frame_done", 32'(frame_done), 32'(exp_done));
        check("frame_len", 32'(frame_len), 32'(exp_len));
        check("in_en", 32'(en_v), 32'(exp_en));
        for (int r = 0; r < ROW; r++)
            check($sformatf("feature_out[%0d]", r), 32'(feature_out[r]), 32'(exp_feat[r]));
        if (busy) st_busy++;
        if (busy && !prev_busy) obs_busy_rise = cyc;
        prev_busy = busy;
        if (in_en[ROW-1]) begin st_en++; st_sum += int'(feature_out[ROW-1]); end
        if (frame_done) begin done_seen = 1; obs_done_cyc = cyc; st_len = int'(frame_len); end
        acc_flag = 0;
        if (nrst && vec_valid && exp_ready) model_accept();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_vec(input logic [ROW*W-1:0] dv, input bit last);
        int  n;
        bit  got;
        for (int r = 0; r < ROW; r++) vec_data[r] = dv[r*W +: W];
        vec_valid = 1; vec_last = last;
        n = 0; got = 0;
        while (!got && n < 100) begin step(); got = acc_flag; n++; end
        vec_valid = 0; vec_last = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_vec cycle %0d: got no accept want accept within 100 cycles", cyc);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done_seen && n < limit) begin step(); n++; end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL wait_done cycle %0d: got no frame_done want pulse within %0d cycles", cyc, limit);
        end
    endtask

    task automatic clear_stats();
        st_busy = 0; st_en = 0; st_sum = 0; st_len = -1; done_seen = 0;
    endtask

    function automatic logic [ROW*W-1:0] seq_vec(input int i, input bit c7);
        logic [ROW*W-1:0] dv;
        for (int r = 0; r < ROW; r++) dv[r*W +: W] = c7 ? W'(7) : W'(i * ROW + r + 1);
        return dv;
    endfunction

    vec_t tbl [6];

    initial begin
        int t0, fa;
        tbl[0] = '{3,  1, 0, 0, 3,  7,  7,  24};
        tbl[1] = '{1,  1, 0, 1, 1,  5,  5,  7};
        tbl[2] = '{16, 0, 0, 0, 16, 20, 20, 544};
        tbl[3] = '{3,  1, 1, 0, 3,  7,  7,  24};
        tbl[4] = '{16, 1, 0, 0, 16, 20, 20, 544};
        tbl[5] = '{15, 1, 0, 0, 15, 19, 19, 480};

        cyc = 0; checks = 0; errors = 0; acc_n = 0; prev_busy = 0;
        nrst = 0; vec_valid = 0; vec_last = 0;
        for (int r = 0; r < ROW; r++) vec_data[r] = '0;
        model_reset();
        clear_stats();
        #1;
        step(); step();
        nrst = 1;
        step();

        // Table of frame shapes with hand-computed results
        for (int k = 0; k < 6; k++) begin
            clear_stats();
            for (int i = 0; i < tbl[k].nvec; i++) begin
                if (tbl[k].gaps && i > 0) begin vec_valid = 0; step(); end
                send_vec(seq_vec(i, tbl[k].const7), tbl[k].mark_last && i == tbl[k].nvec - 1);
            end
            t0 = cyc;
            wait_done(60);
            check($sformatf("tbl%0d done_at", k), 32'(obs_done_cyc - t0), 32'(tbl[k].exp_done));
            check($sformatf("tbl%0d busy_cycles", k), 32'(st_busy), 32'(tbl[k].exp_busy));
            check($sformatf("tbl%0d en_run", k), 32'(st_en), 32'(tbl[k].exp_len));
            check($sformatf("tbl%0d row_sum", k), 32'(st_sum), 32'(tbl[k].exp_sum));
            check($sformatf("tbl%0d frame_len", k), 32'(st_len), 32'(tbl[k].exp_len));
        end

        // Gapped frame, then 0xFF held through drain: accepted only in the frame_done cycle
        clear_stats();
        send_vec(seq_vec(0, 0), 0); vec_valid = 0; step();
        send_vec(seq_vec(1, 0), 0); vec_valid = 0; step();
        send_vec(seq_vec(2, 0), 1);
        send_vec({ROW{8'hFF}}, 0);
        check("ff_accept_at_done", 32'(acc_cyc), 32'(obs_done_cyc));
        check("ff_done_seen", 32'(done_seen), 32'd1);
        clear_stats();
        send_vec(seq_vec(3, 0), 1);
        wait_done(60);
        check("ff_frame_len", 32'(st_len), 32'd2);

        // Back-to-back frames
        clear_stats();
        send_vec(seq_vec(0, 0), 0);
        send_vec(seq_vec(1, 0), 1);
        send_vec(seq_vec(2, 0), 0);
        fa = acc_cyc;
        check("b2b_accept_at_done", 32'(fa), 32'(obs_done_cyc));
        done_seen = 0;
        send_vec(seq_vec(3, 0), 0);
        send_vec(seq_vec(4, 0), 1);
        wait_done(60);
        check("b2b_drain_start", 32'(obs_busy_rise - fa), 32'd3);

        // Asynchronous reset in DRAIN cycle 1 of a 4-vector frame
        for (int i = 0; i < 4; i++) send_vec(seq_vec(i + 5, 0), i == 3);
        step();
        check("pre_reset_in_en0", 32'(in_en[0]), 32'd1);
        nrst = 0;
        #1;
        for (int r = 0; r < ROW; r++) begin
            check($sformatf("async_in_en[%0d]", r), 32'(in_en[r]), 32'd0);
            check($sformatf("async_feature[%0d]", r), 32'(feature_out[r]), 32'd0);
        end
        check("async_busy", 32'(busy), 32'd0);
        check("async_vec_ready", 32'(vec_ready), 32'd1);
        model_reset();
        clear_stats();
        step(); step();
        nrst = 1;
        step();
        check("reset_no_done", 32'(done_seen), 32'd0);
        send_vec(seq_vec(9, 0), 0);
        send_vec(seq_vec(10, 0), 1);
        wait_done(60);
        check("post_reset_len", 32'(st_len), 32'd2);

        // Randomized traffic against the frame model
        for (int i = 0; i < 1500; i++) begin
            vec_valid = ($urandom_range(0, 9) < 7);
            vec_last  = ($urandom_range(0, 5) == 0);
            for (int r = 0; r < ROW; r++) vec_data[r] = W'($urandom);
            step();
        end
        vec_valid = 0; vec_last = 0;
        for (int i = 0; i < 40; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic array wrapper; produces its per-row feature inputs and per-row input enables.
- Accepts one feature column vector per beat (one element per array row) over a valid/ready interface.
- Buffers a whole frame, then streams it out with diagonal skew (row r delayed r cycles) so operands line up in the array.
- Pulses frame_done once the last skewed element has left.

Parameters:
- width, 8, bits per feature element
- row, 4, number of array rows (elements per vector)
- depth, 16, maximum vectors per frame (FIFO entries); power of two, ≥2

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- vec_valid  input  1  upstream vector valid
- vec_ready  output  1  feeder can accept a vector this cycle
- vec_last  input  1  qualifies the final vector of a frame
- vec_data  input  width x row (unpacked [row-1:0])  element r goes to array row r
- feature_out  output  width x row (unpacked [row-1:0])  skewed feature to array row r
- in_en  output  1 x row (unpacked [row-1:0])  per-row input enable to array
- busy  output  1  high in DRAIN and FLUSH
- frame_done  output  1  one-cycle pulse at end of frame
- frame_len  output  $clog2(depth)+1  vectors in current/last frame

Behaviour:
- Reset is asynchronous, active-low, one clock. On reset:
  - state=FILL, FIFO empty, all skew registers cleared.
  - vec_ready=1, feature_out all 0, in_en all 0, busy=0, frame_done=0, frame_len=0.
- States:
  - FILL:
    - vec_ready = (count<depth).
    - A beat is accepted when vec_valid&&vec_ready; it writes vec_data to FIFO[count] and increments count.
    - Leave for DRAIN on an accepted beat with vec_last=1, or on the accepted beat that makes count==depth (implicit last).
    - frame_len latches the final count on that transition. frame_len resets to 0 on the first accept of the next frame.
  - DRAIN:
    - vec_ready=0, busy=1.
    - In DRAIN cycle i (i=0..N-1, N=frame_len) FIFO entry i is read into the skew stage.
    - After cycle N-1 go to FLUSH.
  - FLUSH:
    - vec_ready=0, busy=1.
    - Runs for exactly row cycles, shifting zeros/enable=0 into the skew stage, then returns to FILL with count=0.
- Frame end: frame_done=1 in the first FILL cycle after FLUSH, for exactly 1 cycle. vec_ready is already 1 in that same cycle.
- Skew stage:
  - Row r is a registered pipe of r+1 stages carrying {element, enable}; row 0 has 1 register.
  - Timing is relative to DRAIN cycle 0 = T. Entry i, element r appears on feature_out[r] with in_en[r]=1 at cycle T+1+i+r.
- Output gating:
  - When in_en[r]=0, feature_out[r] must be 0; no stale data.
  - The output stream has no bubbles: in_en[r] is high for N consecutive cycles.
- No backpressure from the array: DRAIN/FLUSH always advance one step per cycle.
- Boundaries:
  - N=1 is legal: vec_last on the first beat.
  - vec_valid while not ready: ignored, no data lost on the feeder side; upstream must hold.
  - vec_last while count==depth-1: accepted as the last beat, N=depth.
  - Reset asserted mid-DRAIN/FLUSH: immediately clears all state and outputs; no frame_done.
- Widths: counters are $clog2(depth)+1 bits and never wrap; count saturates at depth by construction.

Test Plan:
- Basic frame:
  - Stimulus: row=4, depth=16. Send 3 vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}; last has vec_last=1.
  - Required: feature_out[0]=1,5,9 at T+1..T+3; feature_out[3]=4,8,12 at T+4..T+6. in_en matches each window; outputs are 0 elsewhere.
  - Required: busy high for 3+4 cycles; frame_done pulses at T+7; frame_len=3.
- Single-vector frame:
  - Stimulus: {7,7,7,7} with vec_last.
  - Required: in_en[r] high only at T+1+r; frame_done at T+5; frame_len=1.
- Full FIFO, implicit last:
  - Stimulus: 16 vectors, none with vec_last.
  - Required: vec_ready drops after the 16th accept; frame_len=16. Rows 0..3 stream entries 0..15; each in_en run is exactly 16 cycles.
- Upstream stall/gaps and valid while busy:
  - Stimulus: vec_valid toggles 1,0,1,0,1 (last). vec_valid is then held high during DRAIN with data 0xFF.
  - Required: 3 vectors buffered in order. The 0xFF vector is not accepted until vec_ready returns in the frame_done cycle; it becomes entry 0 of the next frame.
- Reset mid-operation:
  - Stimulus: nrst asserted low asynchronously in DRAIN cycle 1 of a 4-vector frame.
  - Required: in_en/feature_out/busy go 0 without waiting for a clock edge; vec_ready=1; frame_done never pulses.
  - Required: a subsequent 2-vector frame streams correctly.
- Back-to-back frames:
  - Stimulus: a 2-vector frame, then a 3-vector frame offered immediately.
  - Required: the second frame's first vector is accepted in the frame_done cycle; its DRAIN starts 3 cycles later. No in_en overlap between frames.
